// File: rtl/swt16_pkg.sv
// Shared constants for the swt16 data-memory path: read-return owner tags
// and the dmem read latency that the arbiter's tag pipeline must match.
package swt16_pkg;

    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_CORE = 2'd1;
    localparam logic [1:0] OWNER_HOST = 2'd2;

    localparam int DMEM_RD_LATENCY = 1;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Counts contended cycles lost by a pending host request and flags the cycle
// in which the host must be granted over the core.
module dmem_arb_starve_ctr #(
    parameter int HOST_WAIT_MAX = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic host_req,
    input  logic core_act,
    output logic force_host
);

    localparam int CNT_W = $clog2(HOST_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(HOST_WAIT_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             contended;

    assign contended  = host_req & core_act;
    assign force_host = contended & (starve_cnt == WAIT_MAX);

    // Any host grant (uncontended or forced) restarts the fairness window.
    // NOTE: state is updated with <= so every always_ff reads pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (host_req && (!core_act || force_host)) begin
            starve_cnt <= '0;
        end else if (contended) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single dmem between the core MEM stage (priority) and a host port
// with a bounded-wait forced host slot; tags reads to route returned data.
module dmem_arbiter
    import swt16_pkg::*;
#(
    parameter int ADDR_WIDTH    = 12,
    parameter int WORD_WIDTH    = 16,
    parameter int HOST_WAIT_MAX = 4,
    parameter int STALL_CNT_W   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_core_rd_en,
    input  logic [ADDR_WIDTH-1:0]  in_core_rd_addr,
    input  logic                   in_core_wr_en,
    input  logic [ADDR_WIDTH-1:0]  in_core_wr_addr,
    input  logic [WORD_WIDTH-1:0]  in_core_wr_word,
    output logic                   out_core_stall,
    output logic                   out_core_rd_valid,
    output logic [WORD_WIDTH-1:0]  out_core_rd_word,
    input  logic                   in_host_req,
    input  logic                   in_host_we,
    input  logic [ADDR_WIDTH-1:0]  in_host_addr,
    input  logic [WORD_WIDTH-1:0]  in_host_wr_word,
    output logic                   out_host_gnt,
    output logic                   out_host_rd_valid,
    output logic [WORD_WIDTH-1:0]  out_host_rd_word,
    output logic [ADDR_WIDTH-1:0]  out_mem_rd_addr,
    output logic [ADDR_WIDTH-1:0]  out_mem_wr_addr,
    output logic [WORD_WIDTH-1:0]  out_mem_wr_word,
    output logic                   out_mem_write_en,
    input  logic [WORD_WIDTH-1:0]  in_mem_rd_word,
    output logic [STALL_CNT_W-1:0] out_stall_count
);

    logic       core_act;
    logic       host_req;
    logic       force_host;
    logic       host_sel;
    logic       core_sel;
    logic [1:0] rd_issue;
    logic [1:0] rd_tag;
    logic [1:0] rd_owner_q [DMEM_RD_LATENCY];

    // Requests are ignored while reset is asserted.
    assign core_act = ~reset & (in_core_rd_en | in_core_wr_en);
    assign host_req = ~reset & in_host_req;

    dmem_arb_starve_ctr #(
        .HOST_WAIT_MAX(HOST_WAIT_MAX)
    ) u_starve (
        .clock     (clock),
        .reset     (reset),
        .host_req  (host_req),
        .core_act  (core_act),
        .force_host(force_host)
    );

    assign host_sel = host_req & (~core_act | force_host);
    assign core_sel = core_act & ~host_sel;

    assign out_host_gnt   = host_sel;
    assign out_core_stall = core_act & host_sel;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        out_mem_rd_addr  = '0;
        out_mem_wr_addr  = '0;
        out_mem_wr_word  = '0;
        out_mem_write_en = 1'b0;
        rd_issue         = OWNER_NONE;
        if (core_sel) begin
            if (in_core_rd_en) begin
                out_mem_rd_addr = in_core_rd_addr;
                rd_issue        = OWNER_CORE;
            end
            if (in_core_wr_en) begin
                out_mem_wr_addr  = in_core_wr_addr;
                out_mem_wr_word  = in_core_wr_word;
                out_mem_write_en = 1'b1;
            end
        end else if (host_sel) begin
            if (in_host_we) begin
                out_mem_wr_addr  = in_host_addr;
                out_mem_wr_word  = in_host_wr_word;
                out_mem_write_en = 1'b1;
            end else begin
                out_mem_rd_addr = in_host_addr;
                rd_issue        = OWNER_HOST;
            end
        end
    end

    // Tag pipeline mirrors the dmem read latency; a reset drops in-flight tags.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DMEM_RD_LATENCY; i++) begin
                rd_owner_q[i] <= OWNER_NONE;
            end
        end else begin
            rd_owner_q[0] <= rd_issue;
            for (int i = 1; i < DMEM_RD_LATENCY; i++) begin
                rd_owner_q[i] <= rd_owner_q[i-1];
            end
        end
    end

    assign rd_tag = rd_owner_q[DMEM_RD_LATENCY-1];

    assign out_core_rd_valid = ~reset & (rd_tag == OWNER_CORE);
    assign out_host_rd_valid = ~reset & (rd_tag == OWNER_HOST);
    assign out_core_rd_word  = out_core_rd_valid ? in_mem_rd_word : '0;
    assign out_host_rd_word  = out_host_rd_valid ? in_mem_rd_word : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_stall_count <= '0;
        end else if (out_core_stall && !(&out_stall_count)) begin
            out_stall_count <= out_stall_count + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: scripted vector table, randomized traffic against a
// rule-level reference model, and counter saturation on a narrow instance.
module tb_dmem_arbiter;

    localparam int AW   = 12;
    localparam int WW   = 16;
    localparam int WAIT = 4;
    localparam int SCW  = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_core_rd_en, in_core_wr_en, in_host_req, in_host_we;
    logic [AW-1:0] in_core_rd_addr, in_core_wr_addr, in_host_addr;
    logic [WW-1:0] in_core_wr_word, in_host_wr_word, in_mem_rd_word;
    logic          out_core_stall, out_core_rd_valid, out_host_gnt, out_host_rd_valid;
    logic [WW-1:0] out_core_rd_word, out_host_rd_word, out_mem_wr_word;
    logic [AW-1:0] out_mem_rd_addr, out_mem_wr_addr;
    logic          out_mem_write_en;
    logic [SCW-1:0] out_stall_count;

    always #5 clock = ~clock;

    dmem_arbiter #(
        .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .HOST_WAIT_MAX(WAIT), .STALL_CNT_W(SCW)
    ) dut (
        .clock(clock), .reset(reset),
        .in_core_rd_en(in_core_rd_en), .in_core_rd_addr(in_core_rd_addr),
        .in_core_wr_en(in_core_wr_en), .in_core_wr_addr(in_core_wr_addr),
        .in_core_wr_word(in_core_wr_word), .out_core_stall(out_core_stall),
        .out_core_rd_valid(out_core_rd_valid), .out_core_rd_word(out_core_rd_word),
        .in_host_req(in_host_req), .in_host_we(in_host_we), .in_host_addr(in_host_addr),
        .in_host_wr_word(in_host_wr_word), .out_host_gnt(out_host_gnt),
        .out_host_rd_valid(out_host_rd_valid), .out_host_rd_word(out_host_rd_word),
        .out_mem_rd_addr(out_mem_rd_addr), .out_mem_wr_addr(out_mem_wr_addr),
        .out_mem_wr_word(out_mem_wr_word), .out_mem_write_en(out_mem_write_en),
        .in_mem_rd_word(in_mem_rd_word), .out_stall_count(out_stall_count)
    );

    // Narrow instance: strict alternation and a 4-bit counter that saturates quickly.
    logic          s_reset, s_crd, s_hreq;
    logic          s_stall, s_cv, s_gnt, s_hv, s_we;
    logic [WW-1:0] s_cw, s_hw, s_wd;
    logic [AW-1:0] s_ra, s_wa;
    logic [3:0]    s_sc;

    dmem_arbiter #(
        .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .HOST_WAIT_MAX(1), .STALL_CNT_W(4)
    ) dut_sat (
        .clock(clock), .reset(s_reset),
        .in_core_rd_en(s_crd), .in_core_rd_addr(12'h001),
        .in_core_wr_en(1'b0), .in_core_wr_addr(12'h000),
        .in_core_wr_word(16'h0000), .out_core_stall(s_stall),
        .out_core_rd_valid(s_cv), .out_core_rd_word(s_cw),
        .in_host_req(s_hreq), .in_host_we(1'b0), .in_host_addr(12'h002),
        .in_host_wr_word(16'h0000), .out_host_gnt(s_gnt),
        .out_host_rd_valid(s_hv), .out_host_rd_word(s_hw),
        .out_mem_rd_addr(s_ra), .out_mem_wr_addr(s_wa),
        .out_mem_wr_word(s_wd), .out_mem_write_en(s_we),
        .in_mem_rd_word(16'h0000), .out_stall_count(s_sc)
    );

    // Behavioural dmem: registered read, write on the edge, read returns old data.
    logic [WW-1:0] mem [4096];
    always @(posedge clock) begin
        if (out_mem_write_en) mem[out_mem_wr_addr] <= out_mem_wr_word;
        in_mem_rd_word <= mem[out_mem_rd_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL cycle %0d %s: got %0h, expected %0h", cyc, name, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int O_NONE = 0, O_CORE = 1, O_HOST = 2;
    logic [WW-1:0] ref_mem [4096];
    int            st_starve = 0;
    int            st_sc     = 0;
    int            pend      = O_NONE;
    logic [WW-1:0] pend_word = '0;

    int            m_owner;
    logic          m_gnt, m_stall, m_cv, m_hv, m_we;
    logic [WW-1:0] m_cw, m_hw, m_wd;
    logic [AW-1:0] m_ra, m_wa;

    task automatic model_eval();
        logic act;
        act     = in_core_rd_en | in_core_wr_en;
        m_owner = O_NONE;
        if (!reset) begin
            if (!in_host_req)          m_owner = act ? O_CORE : O_NONE;
            else if (!act)             m_owner = O_HOST;
            else if (st_starve < WAIT) m_owner = O_CORE;
            else                       m_owner = O_HOST;
        end
        m_gnt   = (m_owner == O_HOST);
        m_stall = (m_owner == O_HOST) && act;
        m_cv    = !reset && pend == O_CORE;
        m_hv    = !reset && pend == O_HOST;
        m_cw    = m_cv ? pend_word : '0;
        m_hw    = m_hv ? pend_word : '0;
        m_ra = '0; m_wa = '0; m_wd = '0; m_we = 1'b0;
        if (m_owner == O_CORE) begin
            if (in_core_rd_en) m_ra = in_core_rd_addr;
            if (in_core_wr_en) begin
                m_wa = in_core_wr_addr; m_wd = in_core_wr_word; m_we = 1'b1;
            end
        end else if (m_owner == O_HOST) begin
            if (in_host_we) begin
                m_wa = in_host_addr; m_wd = in_host_wr_word; m_we = 1'b1;
            end else begin
                m_ra = in_host_addr;
            end
        end
    endtask

    task automatic model_commit();
        if (reset) begin
            st_starve = 0; st_sc = 0; pend = O_NONE;
            return;
        end
        if (m_owner == O_HOST) st_starve = 0;
        else if (in_host_req && m_owner == O_CORE) st_starve++;
        if (m_stall && st_sc < (1 << SCW) - 1) st_sc++;
        pend = O_NONE;
        if (m_owner == O_CORE && in_core_rd_en) begin
            pend = O_CORE; pend_word = ref_mem[in_core_rd_addr];
        end else if (m_owner == O_HOST && !in_host_we) begin
            pend = O_HOST; pend_word = ref_mem[in_host_addr];
        end
        if (m_owner == O_CORE && in_core_wr_en) ref_mem[in_core_wr_addr] = in_core_wr_word;
        if (m_owner == O_HOST && in_host_we)    ref_mem[in_host_addr]    = in_host_wr_word;
    endtask

    task automatic check_mem_port();
        check("mem_rd_addr", 32'(out_mem_rd_addr), 32'(m_ra));
        check("mem_wr_addr", 32'(out_mem_wr_addr), 32'(m_wa));
        check("mem_wr_word", 32'(out_mem_wr_word), 32'(m_wd));
    endtask

    task automatic check_vs_model();
        check("host_gnt",      32'(out_host_gnt),      32'(m_gnt));
        check("core_stall",    32'(out_core_stall),    32'(m_stall));
        check("mem_write_en",  32'(out_mem_write_en),  32'(m_we));
        check("core_rd_valid", 32'(out_core_rd_valid), 32'(m_cv));
        check("core_rd_word",  32'(out_core_rd_word),  32'(m_cw));
        check("host_rd_valid", 32'(out_host_rd_valid), 32'(m_hv));
        check("host_rd_word",  32'(out_host_rd_word),  32'(m_hw));
        check("stall_count",   32'(out_stall_count),   32'(st_sc));
        check_mem_port();
    endtask

    // ---------------- scripted vectors ----------------
    typedef struct {
        string         name;
        logic          rst, crd, cwr, hreq, hwe;
        logic [AW-1:0] cra, cwa, ha;
        logic [WW-1:0] cwd, hwd;
        logic          e_gnt, e_stall, e_we, e_cv, e_hv;
        logic [WW-1:0] e_cw, e_hw, e_sc;
    } vec_t;

    function automatic vec_t vec(
        input string n, input logic rst,
        input logic crd, input logic [AW-1:0] cra,
        input logic cwr, input logic [AW-1:0] cwa, input logic [WW-1:0] cwd,
        input logic hreq, input logic hwe, input logic [AW-1:0] ha, input logic [WW-1:0] hwd,
        input logic gnt, input logic stl, input logic we,
        input logic cv, input logic [WW-1:0] cw, input logic hv, input logic [WW-1:0] hw,
        input logic [WW-1:0] sc);
        vec_t r;
        r.name = n; r.rst = rst;
        r.crd = crd; r.cra = cra; r.cwr = cwr; r.cwa = cwa; r.cwd = cwd;
        r.hreq = hreq; r.hwe = hwe; r.ha = ha; r.hwd = hwd;
        r.e_gnt = gnt; r.e_stall = stl; r.e_we = we;
        r.e_cv = cv; r.e_cw = cw; r.e_hv = hv; r.e_hw = hw; r.e_sc = sc;
        return r;
    endfunction

    task automatic drive(input logic rst, input logic crd, input logic [AW-1:0] cra,
                         input logic cwr, input logic [AW-1:0] cwa, input logic [WW-1:0] cwd,
                         input logic hreq, input logic hwe, input logic [AW-1:0] ha,
                         input logic [WW-1:0] hwd);
        reset = rst;
        in_core_rd_en = crd; in_core_rd_addr = cra;
        in_core_wr_en = cwr; in_core_wr_addr = cwa; in_core_wr_word = cwd;
        in_host_req = hreq; in_host_we = hwe; in_host_addr = ha; in_host_wr_word = hwd;
    endtask

    vec_t tbl[$];
    logic prev_stall, prev_gnt;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 16'(i) ^ 16'hA500;
            ref_mem[i] = 16'(i) ^ 16'hA500;
        end
        mem[12'h010]     = 16'hBEEF;
        ref_mem[12'h010] = 16'hBEEF;

        s_reset = 1'b1; s_crd = 1'b0; s_hreq = 1'b0;
        drive(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clock);
        #1;

        //                 name         rst crd cra     cwr cwa     cwd       hrq hwe ha      hwd       gnt stl we  cv cw        hv hw        sc
        tbl.push_back(vec("reset",      1, 1, 12'h010, 1, 12'h030, 16'hFFFF, 1, 1, 12'h020, 16'hAAAA, 0, 0, 0, 0, 16'h0,    0, 16'h0,    16'd0));
        tbl.push_back(vec("t1_issue",   0, 1, 12'h010, 0, 12'h000, 16'h0,    0, 0, 12'h000, 16'h0,    0, 0, 0, 0, 16'h0,    0, 16'h0,    16'd0));
        tbl.push_back(vec("t1_return",  0, 0, 12'h000, 0, 12'h000, 16'h0,    0, 0, 12'h000, 16'h0,    0, 0, 0, 1, 16'hBEEF, 0, 16'h0,    16'd0));
        tbl.push_back(vec("t2_hwrite",  0, 0, 12'h000, 0, 12'h000, 16'h0,    1, 1, 12'h020, 16'h1234, 1, 0, 1, 0, 16'h0,    0, 16'h0,    16'd0));
        tbl.push_back(vec("t2_hread",   0, 0, 12'h000, 0, 12'h000, 16'h0,    1, 0, 12'h020, 16'h0,    1, 0, 0, 0, 16'h0,    0, 16'h0,    16'd0));
        tbl.push_back(vec("t2_return",  0, 0, 12'h000, 0, 12'h000, 16'h0,    0, 0, 12'h000, 16'h0,    0, 0, 0, 0, 16'h0,    1, 16'h1234, 16'd0));
        tbl.push_back(vec("t3_lose1",   0, 1, 12'h010, 0, 12'h000, 16'h0,    1, 0, 12'h020, 16'h0,    0, 0, 0, 0, 16'h0,    0, 16'h0,    16'd0));
        tbl.push_back(vec("t3_lose2",   0, 1, 12'h010, 0, 12'h000, 16'h0,    1, 0, 12'h020, 16'h0,    0, 0, 0, 1, 16'hBEEF, 0, 16'h0,    16'd0));
        tbl.push_back(vec("t3_lose3",   0, 1, 12'h010, 0, 12'h000, 16'h0,    1, 0, 12'h020, 16'h0,    0, 0, 0, 1, 16'hBEEF, 0, 16'h0,    16'd0));
        tbl.push_back(vec("t3_lose4",   0, 1, 12'h010, 0, 12'h000, 16'h0,    1, 0, 12'h020, 16'h0,    0, 0, 0, 1, 16'hBEEF, 0, 16'h0,    16'd0));
        tbl.push_back(vec("t3_force",   0, 1, 12'h010, 0, 12'h000, 16'h0,    1, 0, 12'h020, 16'h0,    1, 1, 0, 1, 16'hBEEF, 0, 16'h0,    16'd0));
        tbl.push_back(vec("t3_gap",     0, 1, 12'h010, 0, 12'h000, 16'h0,    0, 0, 12'h000, 16'h0,    0, 0, 0, 0, 16'h0,    1, 16'h1234, 16'd1));
        tbl.push_back(vec("t3_resume",  0, 0, 12'h000, 0, 12'h000, 16'h0,    0, 0, 12'h000, 16'h0,    0, 0, 0, 1, 16'hBEEF, 0, 16'h0,    16'd1));
        tbl.push_back(vec("t4_rdwr",    0, 1, 12'h030, 1, 12'h030, 16'h5555, 1, 0, 12'h020, 16'h0,    0, 0, 1, 0, 16'h0,    0, 16'h0,    16'd1));
        tbl.push_back(vec("t4_lose2",   0, 1, 12'h030, 0, 12'h000, 16'h0,    1, 0, 12'h020, 16'h0,    0, 0, 0, 1, 16'hA530, 0, 16'h0,    16'd1));
        tbl.push_back(vec("t4_lose3",   0, 1, 12'h030, 0, 12'h000, 16'h0,    1, 0, 12'h020, 16'h0,    0, 0, 0, 1, 16'h5555, 0, 16'h0,    16'd1));
        tbl.push_back(vec("t4_lose4",   0, 1, 12'h030, 0, 12'h000, 16'h0,    1, 0, 12'h020, 16'h0,    0, 0, 0, 1, 16'h5555, 0, 16'h0,    16'd1));
        tbl.push_back(vec("t4_force",   0, 1, 12'h030, 0, 12'h000, 16'h0,    1, 0, 12'h020, 16'h0,    1, 1, 0, 1, 16'h5555, 0, 16'h0,    16'd1));
        tbl.push_back(vec("t5_reset",   1, 1, 12'h030, 0, 12'h000, 16'h0,    1, 0, 12'h020, 16'h0,    0, 0, 0, 0, 16'h0,    0, 16'h0,    16'd2));
        tbl.push_back(vec("t5_regrant", 0, 0, 12'h000, 0, 12'h000, 16'h0,    1, 0, 12'h020, 16'h0,    1, 0, 0, 0, 16'h0,    0, 16'h0,    16'd0));
        tbl.push_back(vec("t5_return",  0, 0, 12'h000, 0, 12'h000, 16'h0,    0, 0, 12'h000, 16'h0,    0, 0, 0, 0, 16'h0,    1, 16'h1234, 16'd0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].crd, tbl[i].cra, tbl[i].cwr, tbl[i].cwa, tbl[i].cwd,
                  tbl[i].hreq, tbl[i].hwe, tbl[i].ha, tbl[i].hwd);
            model_eval();
            @(negedge clock);
            check({tbl[i].name, ".gnt"},     32'(out_host_gnt),      32'(tbl[i].e_gnt));
            check({tbl[i].name, ".stall"},   32'(out_core_stall),    32'(tbl[i].e_stall));
            check({tbl[i].name, ".we"},      32'(out_mem_write_en),  32'(tbl[i].e_we));
            check({tbl[i].name, ".cvalid"},  32'(out_core_rd_valid), 32'(tbl[i].e_cv));
            check({tbl[i].name, ".cword"},   32'(out_core_rd_word),  32'(tbl[i].e_cw));
            check({tbl[i].name, ".hvalid"},  32'(out_host_rd_valid), 32'(tbl[i].e_hv));
            check({tbl[i].name, ".hword"},   32'(out_host_rd_word),  32'(tbl[i].e_hw));
            check({tbl[i].name, ".scount"},  32'(out_stall_count),   32'(tbl[i].e_sc));
            check_mem_port();
            @(posedge clock);
            model_commit();
            cyc++;
            #1;
        end

        // Randomized traffic: stalled core and ungranted host hold their requests.
        prev_stall = 1'b0;
        prev_gnt   = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            if (!prev_stall) begin
                in_core_rd_en   = 1'($urandom_range(0, 1));
                in_core_wr_en   = ($urandom_range(0, 2) == 0);
                in_core_rd_addr = 12'($urandom_range(0, 31));
                in_core_wr_addr = 12'($urandom_range(0, 31));
                in_core_wr_word = 16'($urandom);
            end
            if (!in_host_req || prev_gnt) begin
                in_host_req     = ($urandom_range(0, 2) == 0);
                in_host_we      = 1'($urandom_range(0, 1));
                in_host_addr    = 12'($urandom_range(0, 31));
                in_host_wr_word = 16'($urandom);
            end
            model_eval();
            @(negedge clock);
            check_vs_model();
            @(posedge clock);
            model_commit();
            prev_stall = m_stall;
            prev_gnt   = m_gnt;
            cyc++;
            #1;
        end

        // Saturation on the narrow instance: a stall every second cycle.
        s_reset = 1'b0; s_crd = 1'b1; s_hreq = 1'b1;
        reset   = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int e_sc;
            e_sc = (k / 2 > 15) ? 15 : k / 2;
            @(negedge clock);
            check("sat_gnt",   32'(s_gnt),   k % 2);
            check("sat_stall", 32'(s_stall), k % 2);
            check("sat_count", 32'(s_sc),    e_sc);
            @(posedge clock);
            cyc++;
            #1;
        end
        @(negedge clock);
        check("sat_hold", 32'(s_sc), 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
